// File: rtl/btn_onoff_if.sv
// Button/LED signal bundle between a stimulus/controller side and the on/off block.
interface btn_onoff_if;
    logic slow_clk;
    logic btn;
    logic btn_db;
    logic press_pulse;
    logic led;

    modport master (
        output slow_clk,
        output btn,
        input  btn_db,
        input  press_pulse,
        input  led
    );

    modport slave (
        input  slow_clk,
        input  btn,
        output btn_db,
        output press_pulse,
        output led
    );
endinterface

// File: rtl/btn_onoff.sv
// Push-button on/off toggle: synchronizer, slow-tick debouncer, and a
// press/release FSM that flips the LED once per debounced press.
module btn_onoff #(
    parameter int unsigned DB_SAMPLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    btn_onoff_if.slave    bus
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DB_SAMPLES);

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_PRESS_ON  = 2'd1,
        ST_ON        = 2'd2,
        ST_PRESS_OFF = 2'd3
    } state_e;

    logic             btn_meta_q;
    logic             btn_s_q;
    logic             slow_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_db_q, btn_db_d;
    logic             db_prev_q;
    state_e           state_q;
    logic             led_q;
    logic             pulse_q;

    logic             tick_c;
    logic             db_rise_c;
    logic             db_fall_c;
    logic [CNT_W-1:0] cnt_inc_c;

    assign tick_c    = bus.slow_clk & ~slow_q;
    assign db_rise_c = btn_db_q & ~db_prev_q;
    assign db_fall_c = ~btn_db_q & db_prev_q;
    assign cnt_inc_c = cnt_q + CNT_W'(1);

    // Debounce: count consecutive disagreeing ticks; any agreeing tick restarts.
    always_comb begin
        cnt_d    = cnt_q;
        btn_db_d = btn_db_q;
        if (tick_c) begin
            if (btn_s_q != btn_db_q) begin
                if (cnt_inc_c == DB_LIMIT) begin
                    btn_db_d = ~btn_db_q;
                    cnt_d    = '0;
                end else begin
                    cnt_d    = cnt_inc_c;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    // slow_q resets high so a slow_clk already high at release is not a tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta_q <= 1'b0;
            btn_s_q    <= 1'b0;
            slow_q     <= 1'b1;
            cnt_q      <= '0;
            btn_db_q   <= 1'b0;
            db_prev_q  <= 1'b0;
        end else begin
            btn_meta_q <= bus.btn;
            btn_s_q    <= btn_meta_q;
            slow_q     <= bus.slow_clk;
            cnt_q      <= cnt_d;
            btn_db_q   <= btn_db_d;
            db_prev_q  <= btn_db_q;
        end
    end

    // Press/release FSM; a held button parks in a PRESS_* state, so no retrigger.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
            led_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                ST_OFF: begin
                    led_q <= 1'b0;
                    if (db_rise_c) begin
                        state_q <= ST_PRESS_ON;
                        led_q   <= 1'b1;
                        pulse_q <= 1'b1;
                    end
                end
                ST_PRESS_ON: begin
                    led_q <= 1'b1;
                    if (db_fall_c) begin
                        state_q <= ST_ON;
                    end
                end
                ST_ON: begin
                    led_q <= 1'b1;
                    if (db_rise_c) begin
                        state_q <= ST_PRESS_OFF;
                        led_q   <= 1'b0;
                        pulse_q <= 1'b1;
                    end
                end
                ST_PRESS_OFF: begin
                    led_q <= 1'b0;
                    if (db_fall_c) begin
                        state_q <= ST_OFF;
                    end
                end
                default: begin
                    state_q <= ST_OFF;
                    led_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.btn_db      = btn_db_q;
    assign bus.press_pulse = pulse_q;
    assign bus.led         = led_q;

endmodule

// File: tb/tb_btn_onoff.sv
// Randomized and directed checks of btn_onoff (DB_SAMPLES=4 and 1) against a
// sample-window reference model.
module tb_btn_onoff;

    logic clk;
    logic rst_v;
    logic slow_v;
    logic btn_v;

    int n_tests;
    int n_fail;

    btn_onoff_if if0 ();
    btn_onoff_if if1 ();

    assign if0.slow_clk = slow_v;
    assign if0.btn      = btn_v;
    assign if1.slow_clk = slow_v;
    assign if1.btn      = btn_v;

    btn_onoff #(.DB_SAMPLES(4)) u_dut4 (.clk(clk), .rst(rst_v), .bus(if0));
    btn_onoff #(.DB_SAMPLES(1)) u_dut1 (.clk(clk), .rst(rst_v), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, one slot per instance.
    int unsigned m_n [2];
    bit          m_dly1 [2];
    bit          m_dly2 [2];
    bit          m_slow_prev [2];
    bit          m_win [2][$];
    bit          m_db [2];
    bit          m_db_prev [2];
    bit          m_led [2];
    bit          m_pulse [2];
    int          m_pcnt [2];
    int          d_pcnt [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Debounced level flips once the last N tick samples all disagree with it.
    task automatic model_step(input int k);
        bit old_db;
        bit tick;
        bit all_diff;
        if (rst_v) begin
            m_dly1[k] = 0; m_dly2[k] = 0; m_slow_prev[k] = 1;
            m_win[k].delete();
            m_db[k] = 0; m_db_prev[k] = 0; m_led[k] = 0; m_pulse[k] = 0;
            return;
        end
        old_db = m_db[k];
        m_pulse[k] = old_db && !m_db_prev[k];
        if (m_pulse[k]) begin
            m_led[k] = !m_led[k];
            m_pcnt[k]++;
        end
        m_db_prev[k] = old_db;
        tick = slow_v && !m_slow_prev[k];
        m_slow_prev[k] = slow_v;
        if (tick) begin
            m_win[k].push_back(m_dly2[k]);
            if (m_win[k].size() > m_n[k]) void'(m_win[k].pop_front());
            if (m_win[k].size() == m_n[k]) begin
                all_diff = 1;
                foreach (m_win[k][i]) if (m_win[k][i] == old_db) all_diff = 0;
                if (all_diff) begin
                    m_db[k] = !old_db;
                    m_win[k].delete();
                end
            end
        end
        m_dly2[k] = m_dly1[k];
        m_dly1[k] = btn_v;
    endtask

    task automatic step();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check("db4",    32'(if0.btn_db),      32'(m_db[0]));
        check("pulse4", 32'(if0.press_pulse), 32'(m_pulse[0]));
        check("led4",   32'(if0.led),         32'(m_led[0]));
        check("db1",    32'(if1.btn_db),      32'(m_db[1]));
        check("pulse1", 32'(if1.press_pulse), 32'(m_pulse[1]));
        check("led1",   32'(if1.led),         32'(m_led[1]));
        if (if0.press_pulse === 1'b1) d_pcnt[0]++;
        if (if1.press_pulse === 1'b1) d_pcnt[1]++;
    endtask

    // One 8-clk slow_clk period; btn set early so its tick samples b.
    task automatic period(input bit b, input int n);
        repeat (n) begin
            btn_v = b;
            slow_v = 0;
            repeat (4) step();
            slow_v = 1;
            repeat (4) step();
        end
    endtask

    int p0;
    int p1;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_n[0] = 4;
        m_n[1] = 1;
        m_pcnt = '{0, 0};
        d_pcnt = '{0, 0};
        rst_v = 1; slow_v = 1; btn_v = 0;
        repeat (3) step();
        check("rst_led", 32'(if0.led), 32'd0);
        check("rst_db", 32'(if0.btn_db), 32'd0);
        rst_v = 0;

        // Full toggle: press, release, press, release.
        period(0, 2);
        p0 = d_pcnt[0];
        period(1, 10);
        check("t_led_p1", 32'(if0.led), 32'd1);
        check("t_db_p1", 32'(if0.btn_db), 32'd1);
        period(0, 10);
        check("t_led_r1", 32'(if0.led), 32'd1);
        period(1, 10);
        check("t_led_p2", 32'(if0.led), 32'd0);
        period(0, 10);
        check("t_led_r2", 32'(if0.led), 32'd0);
        check("t_pulses", 32'(d_pcnt[0] - p0), 32'd2);

        // Bounce: three 1-samples, a 0-sample, then steady 1.
        p0 = d_pcnt[0];
        p1 = d_pcnt[1];
        period(1, 3);
        period(0, 1);
        check("b_db_early", 32'(if0.btn_db), 32'd0);
        period(1, 6);
        check("b_pulses", 32'(d_pcnt[0] - p0), 32'd1);
        check("b_pulses1", 32'(d_pcnt[1] - p1), 32'd2);
        check("b_led", 32'(if0.led), 32'd1);

        // Long hold: no retrigger.
        p0 = d_pcnt[0];
        period(1, 1000);
        check("h_pulses", 32'(d_pcnt[0] - p0), 32'd0);
        check("h_led", 32'(if0.led), 32'd1);

        // Reset mid-debounce, released with slow_clk high.
        period(0, 6);
        period(1, 3);
        check("r_db_pre", 32'(if0.btn_db), 32'd0);
        rst_v = 1; slow_v = 1;
        repeat (3) step();
        check("r_led", 32'(if0.led), 32'd0);
        rst_v = 0;
        step();
        p0 = d_pcnt[0];
        period(1, 3);
        check("r_db_3", 32'(if0.btn_db), 32'd0);
        period(1, 2);
        check("r_db_5", 32'(if0.btn_db), 32'd1);
        check("r_pulses", 32'(d_pcnt[0] - p0), 32'd1);
        check("r_led_on", 32'(if0.led), 32'd1);

        // Random slow_clk, bouncy btn and occasional reset.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 2) == 0) slow_v = ~slow_v;
            if ($urandom_range(0, 9) == 0) btn_v = ~btn_v;
            rst_v = ($urandom_range(0, 199) == 0);
            step();
        end
        rst_v = 0;
        check("rnd_cnt4", 32'(d_pcnt[0]), 32'(m_pcnt[0]));
        check("rnd_cnt1", 32'(d_pcnt[1]), 32'(m_pcnt[1]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_onoff.md
BTN_ONOFF -- requirements
Module: btn_onoff

Interface
REQ-001 SHALL provide parameter DB_SAMPLES, default 4, meaning the number of consecutive slow ticks that must agree before the debounced level changes (legal range 1..255).
REQ-002 SHALL provide port clk, input, 1, system clock; all logic runs on its rising edge.
REQ-003 SHALL provide port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL provide port slow_clk, input, 1, divided clock generated in the clk domain; used only as a data signal, never as a clock.
REQ-005 SHALL provide port btn, input, 1, raw push-button, asynchronous and bouncy.
REQ-006 SHALL provide port btn_db, output, 1, debounced button level.
REQ-007 SHALL provide port press_pulse, output, 1, one clk-cycle strobe on each accepted press.
REQ-008 SHALL provide port led, output, 1, on/off state; 1 = on.

Function
REQ-009 SHALL pass btn through a 2-flop synchronizer (btn_s), giving 2 clk of latency.
REQ-010 SHALL register slow_clk into slow_q each clk; tick = slow_clk & ~slow_q, exactly one clk wide per slow_clk rising edge.
REQ-011 SHALL act on debounce only in cycles where tick=1; all other cycles hold the counter and btn_db.
REQ-012 On a tick with btn_s != btn_db, SHALL increment cnt; when the incremented value equals DB_SAMPLES, SHALL invert btn_db and clear cnt in the same cycle.
REQ-013 On a tick with btn_s == btn_db, SHALL clear cnt, so any bounce restarts the count.
REQ-014 SHALL size cnt at 8 bits; it SHALL never exceed DB_SAMPLES-1 when held.
REQ-015 With DB_SAMPLES=1, SHALL invert btn_db on the first disagreeing tick.
REQ-016 SHALL implement a 4-state FSM with states OFF, PRESS_ON, ON and PRESS_OFF.
REQ-017 FSM transition OFF->PRESS_ON: taken on btn_db rising edge; led becomes 1.
REQ-018 FSM transition PRESS_ON->ON: taken on btn_db falling edge; led stays 1.
REQ-019 FSM transition ON->PRESS_OFF: taken on btn_db rising edge; led becomes 0.
REQ-020 FSM transition PRESS_OFF->OFF: taken on btn_db falling edge; led stays 0.
REQ-021 SHALL detect btn_db edges against a registered copy; FSM state, led and press_pulse SHALL update 1 clk after btn_db changes.
REQ-022 SHALL assert press_pulse for exactly 1 clk on each OFF->PRESS_ON and ON->PRESS_OFF transition, and never in PRESS_ON or PRESS_OFF.
REQ-023 Holding the button SHALL produce no retrigger: exactly one toggle per debounced press regardless of hold length.
REQ-024 led SHALL be a registered output decoded from state (1 in PRESS_ON and ON).
REQ-025 If tick coincides with the cycle btn_s changes, SHALL use the already-registered btn_s value (no bypass).
REQ-026 Unreachable FSM encodings SHALL recover to OFF on the next clk.

Reset
REQ-027 While rst=1, SHALL set btn_s flops=0, cnt=0, btn_db=0, the edge-copy register=0, state=OFF, led=0 and press_pulse=0.
REQ-028 While rst=1, SHALL set slow_q=1 so that no tick fires in the first cycle after release, even if slow_clk=1.
REQ-029 rst asserted mid-debounce or mid-press SHALL abandon all progress; after release the block SHALL behave exactly as from power-up.
REQ-030 Ticks occurring during rst SHALL be ignored.

Verification
REQ-031 Clean press test: DB_SAMPLES=4, slow_clk period 8 clk, btn 0->1 held. Required: btn_db=1 on the 4th tick after btn_s=1; press_pulse 1 clk later for exactly 1 clk; led=1.
REQ-032 Bounce test: btn toggles so ticks 1-3 sample 1, tick 4 samples 0, then steady 1. Required: btn_db stays 0 until the 4th consecutive tick sampling 1; exactly one press_pulse.
REQ-033 Full toggle cycle test: press, release, press, release (each held 10 ticks). Required: led sequence 0->1->1->0; states OFF->PRESS_ON->ON->PRESS_OFF->OFF; exactly 2 press_pulses.
REQ-034 Long hold test: btn held 1000 ticks. Required: a single press_pulse, led=1 throughout, no further toggles.
REQ-035 Reset test: assert rst after 3 agreeing ticks, with slow_clk=1 at release. Required: all outputs 0 during and after rst; no tick in the first cycle after release; 4 fresh agreeing ticks needed before btn_db=1.
REQ-036 DB_SAMPLES=1 test: single press. Required: btn_db=1 on the first tick after btn_s=1; led=1 one clk later.
